// File: rtl/traffic_sensor_frontend.sv
// Car-detector front end for the traffic light controller: synchronises and
// debounces the raw switches, latches arrivals and releases them on green.

module traffic_sensor_channel #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         CNT_W           = 20,
  parameter logic [2:0] GREEN_CODE      = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  input  logic [2:0] light,
  output logic       request,
  output logic       present
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_r;
  logic             request_r;
  logic             rise_s;
  logic             green_s;

  assign rise_s  = stable_r & ~stable_d_r;
  assign green_s = (light == GREEN_CODE);

  // Synchroniser, debouncer, request latch and registered request output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r       <= 1'b0;
      s2_r       <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      req_r      <= 1'b0;
      request_r  <= 1'b0;
    end else begin
      s1_r       <= raw;
      s2_r       <= s1_r;
      stable_d_r <= stable_r;
      // A bounce back to the accepted level restarts the count.
      if (s2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= s2_r;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      // Green wins over a simultaneous arrival: that car is served by this green.
      if (green_s) begin
        req_r <= 1'b0;
      end else if (rise_s) begin
        req_r <= 1'b1;
      end else begin
        req_r <= req_r;
      end
      request_r <= stable_r | req_r;
    end
  end

  assign request = request_r;
  assign present = stable_r;

endmodule

module traffic_sensor_frontend #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         CNT_W           = 20,
  parameter logic [2:0] GREEN_CODE      = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic [2:0] La,
  input  logic [2:0] Lb,
  output logic       sa,
  output logic       sb,
  output logic       present_a,
  output logic       present_b
);

  traffic_sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .GREEN_CODE     (GREEN_CODE)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_a),
    .light  (La),
    .request(sa),
    .present(present_a)
  );

  traffic_sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .GREEN_CODE     (GREEN_CODE)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_b),
    .light  (Lb),
    .request(sb),
    .present(present_b)
  );

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Self-checking bench for traffic_sensor_frontend with a window-based
// reference model of debounce, request latching and green clearing.

module tb_traffic_sensor_frontend;

  localparam int         D     = 4;
  localparam int         CW    = 3;
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] RED   = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_a = 1'b0;
  logic       raw_b = 1'b0;
  logic [2:0] La = RED;
  logic [2:0] Lb = RED;
  logic       sa, sb, present_a, present_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: accepted level, "rose at last edge", latch, output.
  bit m_stable [2];
  bit m_rose   [2];
  bit m_req    [2];
  bit m_out    [2];
  bit hist_a[$];
  bit hist_b[$];

  traffic_sensor_frontend #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW),
    .GREEN_CODE     (GREEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_a    (raw_a),
    .raw_b    (raw_b),
    .La       (La),
    .Lb       (Lb),
    .sa       (sa),
    .sb       (sb),
    .present_a(present_a),
    .present_b(present_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("sa", sa, m_out[0]);
    check("sb", sb, m_out[1]);
    check("present_a", present_a, m_stable[0]);
    check("present_b", present_b, m_stable[1]);
  endtask

  // A level is accepted once the raw samples taken 2..D+1 edges ago all agree.
  function automatic bit debounce_next(input bit cur, input bit h[$]);
    int n = h.size();
    bit v = h[n-3];
    for (int i = 3; i <= D + 2; i++) begin
      if (h[n-i] != v) return cur;
    end
    return v;
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < D + 2; i++) begin
      hist_a.push_back(1'b0);
      hist_b.push_back(1'b0);
    end
    for (int x = 0; x < 2; x++) begin
      m_stable[x] = 1'b0;
      m_rose[x]   = 1'b0;
      m_req[x]    = 1'b0;
      m_out[x]    = 1'b0;
    end
  endtask

  task automatic model_edge(input bit ra, input bit rb, input logic [2:0] la, input logic [2:0] lb);
    bit ns [2];
    for (int x = 0; x < 2; x++) begin
      m_out[x] = m_stable[x] | m_req[x];
      if (((x == 0) ? la : lb) == GREEN) m_req[x] = 1'b0;
      else if (m_rose[x])                m_req[x] = 1'b1;
    end
    hist_a.push_back(ra);
    hist_b.push_back(rb);
    if (hist_a.size() > 16) void'(hist_a.pop_front());
    if (hist_b.size() > 16) void'(hist_b.pop_front());
    ns[0] = debounce_next(m_stable[0], hist_a);
    ns[1] = debounce_next(m_stable[1], hist_b);
    for (int x = 0; x < 2; x++) begin
      m_rose[x]   = ns[x] & ~m_stable[x];
      m_stable[x] = ns[x];
    end
  endtask

  // Called 1 time unit after an edge: drive, clock, model, compare.
  task automatic tick(input bit ra, input bit rb, input logic [2:0] la, input logic [2:0] lb);
    raw_a = ra;
    raw_b = rb;
    La    = la;
    Lb    = lb;
    @(posedge clk);
    model_edge(ra, rb, la, lb);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (n) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  function automatic logic [2:0] pick_light();
    if ($urandom_range(0, 3) == 0) return GREEN;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // 1: clean rise on a, exact latency.
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0, RED, RED);
      if (i == 5) check("t1_present_a_e5", present_a, 1'b0);
      if (i == 6) check("t1_present_a_e6", present_a, 1'b1);
      if (i == 6) check("t1_sa_e6", sa, 1'b0);
      if (i == 7) check("t1_sa_e7", sa, 1'b1);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, RED, RED);
    check("t1_sa_latched", sa, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, GREEN, RED);
    check("t1_sa_cleared", sa, 1'b0);
    check("t1_sb_idle", sb, 1'b0);

    // 2: bouncing rise on a.
    do_reset(2);
    for (int i = 1; i <= 14; i++) begin
      tick((i <= 4) ? ((i % 2) == 1) : 1'b1, 1'b0, RED, RED);
      if (i == 9)  check("t2_present_a_e9", present_a, 1'b0);
      if (i == 10) check("t2_present_a_e10", present_a, 1'b1);
    end

    // 3: short car on b latched, then served by green.
    do_reset(2);
    for (int i = 0; i < 6; i++)  tick(1'b0, 1'b1, RED, RED);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, RED, RED);
    check("t3_sb_latched", sb, 1'b1);
    check("t3_present_b_gone", present_b, 1'b0);
    tick(1'b0, 1'b0, RED, GREEN);
    check("t3_sb_green_e1", sb, 1'b1);
    tick(1'b0, 1'b0, RED, GREEN);
    check("t3_sb_green_e2", sb, 1'b0);

    // 4: arrival during green never latches.
    do_reset(2);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, GREEN, RED);
    check("t4_sa_level", sa, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, GREEN, RED);
    check("t4_sa_released", sa, 1'b0);

    // 5: simultaneous arrivals, green on a only.
    do_reset(2);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b1, RED, RED);
      if (i == 7) check("t5_sa_e7", sa, 1'b1);
      if (i == 7) check("t5_sb_e7", sb, 1'b1);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, RED, RED);
    for (int i = 0; i < 3; i++)  tick(1'b0, 1'b0, GREEN, RED);
    check("t5_sa_cleared", sa, 1'b0);
    check("t5_sb_kept", sb, 1'b1);

    // 6: reset with sa high and b mid-count, then a fresh debounce.
    do_reset(2);
    for (int i = 0; i < 8; i++) tick(1'b1, (i >= 4), RED, RED);
    check("t6_sa_before", sa, 1'b1);
    do_reset(1);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0, RED, RED);
      if (i == 6) check("t6_sa_e6", sa, 1'b0);
      if (i == 7) check("t6_sa_e7", sa, 1'b1);
    end

    // Randomised runs of held levels with random light codes.
    for (int seg = 0; seg < 400; seg++) begin
      bit ra, rb;
      logic [2:0] la, lb;
      int len;
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      la  = pick_light();
      lb  = pick_light();
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) tick(ra, rb, la, lb);
      if ((seg % 100) == 99) do_reset(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
